// File: rtl/bldc_pkg.sv
// Shared constants and types for the BLDC velocity-controller encoder path.
package bldc_pkg;

    localparam int TICKS_PER_REV_DEFAULT = 8192;
    localparam int POLE_PAIRS            = 7;
    localparam int TICKS_PER_ECYCLE      = 1170;
    localparam int QUARTER_ECYCLE        = 292;

    typedef logic [12:0] enc_ticks_t;

    typedef enum logic {ENC_INIT, ENC_TRACK} enc_state_t;

    // Position of an {A,B} pair along the forward cycle 00->10->11->01; the
    // modulo-4 difference of two phases classifies a transition.
    function automatic logic [1:0] gray_phase(input logic [1:0] ab);
        case (ab)
            2'b00:   gray_phase = 2'd0;
            2'b10:   gray_phase = 2'd1;
            2'b11:   gray_phase = 2'd2;
            default: gray_phase = 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/quadrature_encoder_counter_if.sv
// Encoder pins in, decoded position/status out; master is the encoder side, slave the decoder.
interface quadrature_encoder_counter_if;
    import bldc_pkg::*;

    logic       enc_a;
    logic       enc_b;
    logic       enc_index;
    enc_ticks_t encoder_ticks;
    logic       direction;
    logic       tick_strobe;
    logic       illegal_transition;
    logic [7:0] error_count;
    logic       index_seen;

    modport master (
        output enc_a, enc_b, enc_index,
        input  encoder_ticks, direction, tick_strobe, illegal_transition, error_count, index_seen
    );

    modport slave (
        input  enc_a, enc_b, enc_index,
        output encoder_ticks, direction, tick_strobe, illegal_transition, error_count, index_seen
    );

endinterface

// File: rtl/enc_input_filter.sv
// Two-flop synchroniser plus FILTER_CYCLES debounce for one asynchronous encoder pin.
// valid_o rises once a first stable level has been acquired after reset.
module enc_input_filter #(
    parameter int FILTER_CYCLES = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pin_i,
    output logic level_o,
    output logic valid_o
);

    localparam int CNT_W = $clog2(FILTER_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FILTER_CYCLES);

    logic             sync1_q, sync2_q;
    logic [1:0]       primed_q;
    logic             level_q, level_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] run_len;

    // primed_q keeps the reset-cleared synchroniser contents out of the filter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            primed_q <= 2'b00;
        end else begin
            sync1_q  <= pin_i;
            sync2_q  <= sync1_q;
            primed_q <= {primed_q[0], 1'b1};
        end
    end

    always_comb begin
        level_d = level_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        run_len = (sync2_q == level_q && cnt_q != '0) ? cnt_q + CNT_ONE : CNT_ONE;
        if (primed_q[1]) begin
            if (!valid_q) begin
                // Acquisition: follow the pin until one level persists FILTER_CYCLES samples.
                level_d = sync2_q;
                if (run_len == CNT_FULL) begin
                    valid_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = run_len;
                end
            end else if (sync2_q != level_q) begin
                if (cnt_q == CNT_LAST) begin
                    level_d = sync2_q;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end else begin
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level_q <= 1'b0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            level_q <= level_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/quadrature_encoder_counter.sv
// Quadrature A/B(/index) decoder producing a wrapping rotor position, direction and error flags.
// Index re-zeroing is built only when INDEX_RESET_EN is defined.
module quadrature_encoder_counter
    import bldc_pkg::*;
#(
    parameter int TICKS_PER_REV = TICKS_PER_REV_DEFAULT,
    parameter int FILTER_CYCLES = 4,
    parameter int INDEX_OFFSET  = 0
) (
    input logic                         clk,
    input logic                         reset_n,
    quadrature_encoder_counter_if.slave bus
);

    localparam logic [13:0] TPR14  = 14'(TICKS_PER_REV);
    localparam logic [13:0] TPR_M1 = 14'(TICKS_PER_REV - 1);

    logic [1:0] rst_sync_q;
    logic       rst_int_n;
    logic       a_level, a_valid, b_level, b_valid, all_valid;
    logic [1:0] cur_ab, phase_delta;
    logic [13:0] step_sum;

    enc_state_t state_q, state_d;
    logic [1:0] prev_ab_q, prev_ab_d;
    enc_ticks_t ticks_q, ticks_d;
    logic       dir_q, dir_d;
    logic       strobe_q, strobe_d;
    logic       illegal_q, illegal_d;
    logic [7:0] err_q, err_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync_q <= 2'b00;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_int_n = rst_sync_q[1];

    enc_input_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filt_a (
        .clk(clk), .reset_n(rst_int_n), .pin_i(bus.enc_a), .level_o(a_level), .valid_o(a_valid)
    );
    enc_input_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filt_b (
        .clk(clk), .reset_n(rst_int_n), .pin_i(bus.enc_b), .level_o(b_level), .valid_o(b_valid)
    );

`ifdef INDEX_RESET_EN
    logic idx_level, idx_valid, index_load;
    logic prev_idx_q, seen_q;

    enc_input_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filt_idx (
        .clk(clk), .reset_n(rst_int_n), .pin_i(bus.enc_index), .level_o(idx_level), .valid_o(idx_valid)
    );

    assign all_valid  = a_valid & b_valid & idx_valid;
    assign index_load = (state_q == ENC_TRACK) && idx_level && !prev_idx_q;

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            prev_idx_q <= 1'b0;
            seen_q     <= 1'b0;
        end else begin
            prev_idx_q <= idx_level;
            seen_q     <= seen_q | index_load;
        end
    end
    assign bus.index_seen = seen_q;
`else
    logic unused_index;
    assign unused_index   = bus.enc_index;
    assign all_valid      = a_valid & b_valid;
    assign bus.index_seen = 1'b0;
`endif

    assign cur_ab      = {a_level, b_level};
    assign phase_delta = gray_phase(cur_ab) - gray_phase(prev_ab_q);
    assign step_sum    = {1'b0, ticks_q} + ((phase_delta == 2'd1) ? 14'd1 : TPR_M1);

    always_comb begin
        state_d   = state_q;
        prev_ab_d = prev_ab_q;
        ticks_d   = ticks_q;
        dir_d     = dir_q;
        strobe_d  = 1'b0;
        illegal_d = 1'b0;
        err_d     = err_q;
        case (state_q)
            ENC_INIT: begin
                if (all_valid) begin
                    prev_ab_d = cur_ab;
                    state_d   = ENC_TRACK;
                end
            end
            ENC_TRACK: begin
                prev_ab_d = cur_ab;
                // Phase delta 1 is a forward step, 3 a reverse step, 2 a skipped state.
                if (phase_delta == 2'd1 || phase_delta == 2'd3) begin
                    ticks_d  = (step_sum >= TPR14) ? enc_ticks_t'(step_sum - TPR14)
                                                   : enc_ticks_t'(step_sum);
                    dir_d    = (phase_delta == 2'd1);
                    strobe_d = 1'b1;
                end else if (phase_delta == 2'd2) begin
                    illegal_d = 1'b1;
                    if (err_q != 8'hFF) err_d = err_q + 8'd1;
                end
`ifdef INDEX_RESET_EN
                if (index_load) begin
                    ticks_d  = enc_ticks_t'(INDEX_OFFSET);
                    strobe_d = 1'b0;
                end
`endif
            end
            default: state_d = ENC_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q   <= ENC_INIT;
            prev_ab_q <= 2'b00;
            ticks_q   <= '0;
            dir_q     <= 1'b1;
            strobe_q  <= 1'b0;
            illegal_q <= 1'b0;
            err_q     <= 8'd0;
        end else begin
            state_q   <= state_d;
            prev_ab_q <= prev_ab_d;
            ticks_q   <= ticks_d;
            dir_q     <= dir_d;
            strobe_q  <= strobe_d;
            illegal_q <= illegal_d;
            err_q     <= err_d;
        end
    end

    assign bus.encoder_ticks      = ticks_q;
    assign bus.direction          = dir_q;
    assign bus.tick_strobe        = strobe_q;
    assign bus.illegal_transition = illegal_q;
    assign bus.error_count        = err_q;

endmodule

// File: tb/tb_quadrature_encoder_counter.sv
// Bench for quadrature_encoder_counter: directed and random encoder motion against a
// position/direction/error model; index checks depend on INDEX_RESET_EN.
module tb_quadrature_encoder_counter;

    localparam int TPR    = 8192;
    localparam int OFFSET = 100;

    logic clk = 1'b0;
    logic reset_n;

    quadrature_encoder_counter_if bus ();

    quadrature_encoder_counter #(
        .TICKS_PER_REV(TPR),
        .FILTER_CYCLES(4),
        .INDEX_OFFSET(OFFSET)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    // Reference model: integer position and forward-successor table for {A,B}.
    logic [1:0] fwdNext [4];
    logic [1:0] modelAB;
    logic       modelIdx;
    int modelPos, modelDir, modelErr, modelSeen;
    int modelStrobes  = 0;
    int modelIllegals = 0;

    int obsStrobes  = 0;
    int obsIllegals = 0;

    // Pulse counters sample on the falling edge, away from register updates.
    always @(negedge clk) begin
        if (bus.tick_strobe === 1'b1)        obsStrobes++;
        if (bus.illegal_transition === 1'b1) obsIllegals++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic checkState(input string tag);
        checkOutput({tag, ".ticks"},    32'(bus.encoder_ticks), modelPos);
        checkOutput({tag, ".dir"},      32'(bus.direction),     modelDir);
        checkOutput({tag, ".strobes"},  obsStrobes,             modelStrobes);
        checkOutput({tag, ".illegals"}, obsIllegals,            modelIllegals);
        checkOutput({tag, ".errors"},   32'(bus.error_count),   modelErr);
        checkOutput({tag, ".seen"},     32'(bus.index_seen),    modelSeen);
    endtask

    task automatic modelStep(input logic [1:0] newAB, input logic idx);
        bit strobe = 0;
        bit rise   = idx && !modelIdx;
        if (newAB == fwdNext[modelAB]) begin
            modelPos = (modelPos + 1) % TPR;
            modelDir = 1;
            strobe   = 1;
        end else if (modelAB == fwdNext[newAB]) begin
            modelPos = (modelPos + TPR - 1) % TPR;
            modelDir = 0;
            strobe   = 1;
        end else if (newAB != modelAB) begin
            modelIllegals++;
            if (modelErr < 255) modelErr++;
        end
`ifdef INDEX_RESET_EN
        if (rise) begin
            modelPos  = OFFSET;
            modelSeen = 1;
            strobe    = 0;
        end
`else
        rise = 0;
`endif
        if (strobe) modelStrobes++;
        modelAB  = newAB;
        modelIdx = idx;
    endtask

    // Drive new pin levels on a falling edge and hold them for 'hold' cycles.
    task automatic applyStimulus(input logic a, input logic b, input logic idx, input int hold);
        bus.enc_a     = a;
        bus.enc_b     = b;
        bus.enc_index = idx;
        modelStep({a, b}, idx);
        repeat (hold) @(negedge clk);
    endtask

    task automatic applyReset(input string tag);
        reset_n = 1'b0;
        #1;
        checkOutput({tag, ".rst_ticks"},   32'(bus.encoder_ticks),      0);
        checkOutput({tag, ".rst_dir"},     32'(bus.direction),          1);
        checkOutput({tag, ".rst_strobe"},  32'(bus.tick_strobe),        0);
        checkOutput({tag, ".rst_illegal"}, 32'(bus.illegal_transition), 0);
        checkOutput({tag, ".rst_errors"},  32'(bus.error_count),        0);
        checkOutput({tag, ".rst_seen"},    32'(bus.index_seen),         0);
        repeat (3) @(negedge clk);
        reset_n   = 1'b1;
        modelPos  = 0;
        modelDir  = 1;
        modelErr  = 0;
        modelSeen = 0;
        modelAB   = {bus.enc_a, bus.enc_b};
        modelIdx  = bus.enc_index;
        repeat (20) @(negedge clk);
    endtask

    initial begin
        logic [1:0] ab;
        int r;
        fwdNext[0] = 2'b10;
        fwdNext[1] = 2'b00;
        fwdNext[2] = 2'b11;
        fwdNext[3] = 2'b01;
        reset_n       = 1'b0;
        bus.enc_a     = 1'b0;
        bus.enc_b     = 1'b0;
        bus.enc_index = 1'b0;
        repeat (2) @(negedge clk);

        applyReset("reset");
        checkState("post_reset");

        for (int i = 0; i < 4; i++) begin
            ab = fwdNext[modelAB];
            applyStimulus(ab[1], ab[0], 1'b0, 10);
            checkState($sformatf("fwd%0d", i));
        end

        applyReset("reset2");
        checkState("post_reset2");
        applyStimulus(1'b0, 1'b1, 1'b0, 10);
        checkState("rev_wrap");
        applyStimulus(1'b0, 1'b0, 1'b0, 10);
        checkState("fwd_wrap");

        // A-channel glitch one sample shorter than the filter window.
        bus.enc_a = 1'b1;
        repeat (3) @(negedge clk);
        bus.enc_a = 1'b0;
        repeat (10) @(negedge clk);
        checkState("glitch");

        applyStimulus(1'b1, 1'b1, 1'b0, 10);
        checkState("illegal1");
        for (int i = 0; i < 255; i++) begin
            if (i % 2 == 0) applyStimulus(1'b0, 1'b0, 1'b0, 8);
            else            applyStimulus(1'b1, 1'b1, 1'b0, 8);
        end
        checkState("illegal_sat");

        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 9);
            if (r < 4)       ab = fwdNext[modelAB];
            else if (r < 8)  ab = (fwdNext[0] == modelAB) ? 2'b00 :
                                  (fwdNext[1] == modelAB) ? 2'b01 :
                                  (fwdNext[2] == modelAB) ? 2'b10 : 2'b11;
            else if (r == 8) ab = modelAB;
            else             ab = modelAB ^ 2'b11;
            applyStimulus(ab[1], ab[0], 1'b0, int'($urandom_range(8, 12)));
            checkState($sformatf("rand%0d", i));
        end

        // Reset while parked on a non-zero phase: the re-acquired level must not count.
        ab = (modelAB == 2'b00) ? fwdNext[modelAB] : modelAB;
        applyStimulus(ab[1], ab[0], 1'b0, 10);
        applyReset("reset_mid");
        checkState("post_reset_mid");
        ab = fwdNext[modelAB];
        applyStimulus(ab[1], ab[0], 1'b0, 10);
        checkState("resume");

`ifdef INDEX_RESET_EN
        while (modelPos != 500) begin
            ab = fwdNext[modelAB];
            applyStimulus(ab[1], ab[0], 1'b0, 8);
        end
        checkState("at500");
        ab = fwdNext[modelAB];
        applyStimulus(ab[1], ab[0], 1'b1, 10);
        checkState("index_load");
        applyStimulus(ab[1], ab[0], 1'b0, 10);
        checkState("index_fall");
        ab = fwdNext[modelAB];
        applyStimulus(ab[1], ab[0], 1'b0, 10);
        checkState("after_index");
`else
        applyStimulus(modelAB[1], modelAB[0], 1'b1, 10);
        checkState("index_ignored");
        applyStimulus(modelAB[1], modelAB[0], 1'b0, 10);
        checkState("index_ignored_fall");
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
